// File: rtl/ex_pkg.sv
// ex_pkg: shared constants and types for the RV32I execute stage.
//   - Opcode constants for the instruction classes handled by ex_alu.
//   - funct3 encodings for the base ALU group and the M-extension multiplies.
//   - State enumeration for the execute-stage sequencer.
package ex_pkg;

  // Major opcodes handled by the execute stage
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  // funct3 for OP / OP-IMM with funct7 != M-extension
  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_SLL    = 3'b001;
  localparam logic [2:0] F3_SLT    = 3'b010;
  localparam logic [2:0] F3_SLTU   = 3'b011;
  localparam logic [2:0] F3_XOR    = 3'b100;
  localparam logic [2:0] F3_SR     = 3'b101;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

  // funct3 for the M-extension multiply group (st[2] = 0)
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;

  // Execute-stage sequencer: single-cycle ops live in IDLE, multiplies in MUL
  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/ex_mul.sv
// ex_mul: iterative shift-add multiplier for the M-extension multiplies.
//   Operands are reduced to magnitudes, an unsigned 2*XLEN product is
//   accumulated one multiplier bit per cycle, and the product is negated when
//   the operand signs differ. The last accumulation step is resolved
//   combinationally so that result is valid in the same cycle done is high.
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high clear (also used to abort)
//   start    in   load operands and begin a new multiply
//   a, b     in   XLEN-bit operands (sampled when start is high)
//   a_signed in   treat a as two's complement
//   b_signed in   treat b as two's complement
//   hi_sel   in   return the upper XLEN bits of the product
//   done     out  result is valid this cycle (one-cycle pulse)
//   result   out  selected half of the signed-corrected product
module ex_mul #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            a_signed,
  input  logic            b_signed,
  input  logic            hi_sel,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);

  logic [2*XLEN-1:0] mcand_r;
  logic [2*XLEN-1:0] acc_r;
  logic [XLEN-1:0]   mplier_r;
  logic [CW-1:0]     cnt_r;
  logic              busy_r;
  logic              neg_r;
  logic              hi_r;

  logic [2*XLEN-1:0] acc_nxt_s;
  logic [2*XLEN-1:0] prod_s;

  // Magnitude of an operand; the most-negative value maps to itself, which is
  // the correct unsigned magnitude.
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic is_signed);
    if (is_signed && v[XLEN-1]) begin
      magnitude = -v;
    end else begin
      magnitude = v;
    end
  endfunction

  // Next accumulator value and signed fix-up of the product
  always_comb begin
    acc_nxt_s = acc_r;
    if (mplier_r[0]) begin
      acc_nxt_s = acc_r + mcand_r;
    end else begin
      acc_nxt_s = acc_r;
    end
    if (neg_r) begin
      prod_s = -acc_nxt_s;
    end else begin
      prod_s = acc_nxt_s;
    end
  end

  // Half selection and completion flag
  always_comb begin
    done = busy_r && (cnt_r == LAST_ITER);
    if (hi_r) begin
      result = prod_s[2*XLEN-1:XLEN];
    end else begin
      result = prod_s[XLEN-1:0];
    end
  end

  // Iteration state: load on start, one shift-add step per busy cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_r  <= {(2*XLEN){1'b0}};
      acc_r    <= {(2*XLEN){1'b0}};
      mplier_r <= {XLEN{1'b0}};
      cnt_r    <= {CW{1'b0}};
      busy_r   <= 1'b0;
      neg_r    <= 1'b0;
      hi_r     <= 1'b0;
    end else if (start) begin
      mcand_r  <= {{XLEN{1'b0}}, magnitude(a, a_signed)};
      acc_r    <= {(2*XLEN){1'b0}};
      mplier_r <= magnitude(b, b_signed);
      cnt_r    <= {CW{1'b0}};
      busy_r   <= 1'b1;
      neg_r    <= (a_signed & a[XLEN-1]) ^ (b_signed & b[XLEN-1]);
      hi_r     <= hi_sel;
    end else if (busy_r) begin
      acc_r    <= acc_nxt_s;
      mcand_r  <= {mcand_r[2*XLEN-2:0], 1'b0};
      mplier_r <= {1'b0, mplier_r[XLEN-1:1]};
      cnt_r    <= cnt_r + CW'(1);
      busy_r   <= !done;
    end else begin
      busy_r   <= 1'b0;
    end
  end

endmodule

// File: rtl/ex_alu.sv
// ex_alu: registered RV32I execute stage.
//   Computes the OP / OP-IMM ALU functions plus LUI and AUIPC in one cycle.
//   With EX_MUL_EN defined, OP ops with the M-extension funct7 and st[2] = 0
//   (MUL/MULH/MULHSU/MULHU) run on the iterative ex_mul unit, stalling decode
//   through in_ready for XLEN cycles. Without EX_MUL_EN those ops, and any
//   opcode not listed above, complete in one cycle with wn = 0 and we_o = 0.
// Configuration macro: EX_MUL_EN (enables the multiplier and the MUL state).
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   flush              squash the current op and any in-flight multiply
//   in_valid/in_ready  decode handshake; accept on in_valid && in_ready
//   t, st, sst, m      opcode, funct3, funct7[5], M-extension select
//   n1, n2             operands (rs1 or PC, rs2 or immediate)
//   wa, we             destination register and write-enable
//   out_valid          one-cycle pulse per completed op
//   wa_o, we_o, wn     registered destination, write-enable and result
module ex_alu
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      t,
  input  logic [2:0]      st,
  input  logic            sst,
  input  logic            m,
  input  logic [XLEN-1:0] n1,
  input  logic [XLEN-1:0] n2,
  input  logic [4:0]      wa,
  input  logic            we,
  output logic            out_valid,
  output logic [4:0]      wa_o,
  output logic            we_o,
  output logic [XLEN-1:0] wn
);

  localparam int SHW = $clog2(XLEN);

  logic            out_valid_r;
  logic [4:0]      wa_o_r;
  logic            we_o_r;
  logic [XLEN-1:0] wn_r;

  logic            accept_s;
  logic            supported_s;
  logic [XLEN-1:0] alu_res_s;

  // Base integer ALU; sub selects subtraction, arith selects SRA over SRL
  function automatic logic [XLEN-1:0] alu_fn(
    input logic [2:0]      f3,
    input logic            sub,
    input logic            arith,
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b
  );
    logic [SHW-1:0] sh;
    sh = b[SHW-1:0];
    case (f3)
      F3_ADDSUB: begin
        if (sub) begin
          alu_fn = a - b;
        end else begin
          alu_fn = a + b;
        end
      end
      F3_SLL:  alu_fn = a << sh;
      F3_SLT:  alu_fn = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      F3_SLTU: alu_fn = {{(XLEN-1){1'b0}}, (a < b)};
      F3_XOR:  alu_fn = a ^ b;
      F3_SR: begin
        if (arith) begin
          alu_fn = $unsigned($signed(a) >>> sh);
        end else begin
          alu_fn = a >> sh;
        end
      end
      F3_OR:   alu_fn = a | b;
      F3_AND:  alu_fn = a & b;
      default: alu_fn = {XLEN{1'b0}};
    endcase
  endfunction

  // Single-cycle decode: result and whether the op is a supported one.
  // SUB only exists in the register form; OP-IMM bit 30 is immediate data
  // except for SRAI, so it only steers the shift there.
  always_comb begin
    supported_s = 1'b1;
    alu_res_s   = {XLEN{1'b0}};
    case (t)
      OPC_OPIMM: alu_res_s = alu_fn(st, 1'b0, sst, n1, n2);
      OPC_OP: begin
        if (m) begin
          supported_s = 1'b0;
        end else begin
          alu_res_s = alu_fn(st, sst, sst, n1, n2);
        end
      end
      OPC_LUI:   alu_res_s = n2;
      OPC_AUIPC: alu_res_s = n1 + n2;
      default:   supported_s = 1'b0;
    endcase
  end

`ifdef EX_MUL_EN
  state_t          state_r;
  logic [4:0]      pend_wa_r;
  logic            pend_we_r;

  logic            is_mul_s;
  logic            mul_start_s;
  logic            mul_clr_s;
  logic            mul_as_s;
  logic            mul_bs_s;
  logic            mul_hi_s;
  logic            mul_done_s;
  logic [XLEN-1:0] mul_res_s;

  assign in_ready    = !rst && (state_r == IDLE);
  // flush wins over a simultaneous accept
  assign accept_s    = in_valid && in_ready && !flush;
  assign is_mul_s    = (t == OPC_OP) && m && !st[2];
  assign mul_start_s = accept_s && is_mul_s;
  // rst or flush abort any multiply in flight so it never reports done
  assign mul_clr_s   = rst || flush;

  // Operand signedness and half selection for each multiply flavour
  always_comb begin
    mul_as_s = 1'b0;
    mul_bs_s = 1'b0;
    mul_hi_s = 1'b1;
    case (st)
      F3_MULH: begin
        mul_as_s = 1'b1;
        mul_bs_s = 1'b1;
      end
      F3_MULHSU: mul_as_s = 1'b1;
      F3_MULHU:  mul_hi_s = 1'b1;
      F3_MUL:    mul_hi_s = 1'b0;
      default:   mul_hi_s = 1'b0;
    endcase
  end

  ex_mul #(.XLEN(XLEN)) u_mul (
    .clk      (clk),
    .rst      (mul_clr_s),
    .start    (mul_start_s),
    .a        (n1),
    .b        (n2),
    .a_signed (mul_as_s),
    .b_signed (mul_bs_s),
    .hi_sel   (mul_hi_s),
    .done     (mul_done_s),
    .result   (mul_res_s)
  );

  // Sequencer and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      pend_wa_r   <= 5'd0;
      pend_we_r   <= 1'b0;
      out_valid_r <= 1'b0;
      wa_o_r      <= 5'd0;
      we_o_r      <= 1'b0;
      wn_r        <= {XLEN{1'b0}};
    end else if (flush) begin
      state_r     <= IDLE;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s && is_mul_s) begin
            pend_wa_r   <= wa;
            pend_we_r   <= we;
            out_valid_r <= 1'b0;
            state_r     <= MUL;
          end else if (accept_s) begin
            out_valid_r <= 1'b1;
            wa_o_r      <= wa;
            we_o_r      <= we && supported_s;
            wn_r        <= alu_res_s;
          end else begin
            out_valid_r <= 1'b0;
          end
        end
        MUL: begin
          if (mul_done_s) begin
            out_valid_r <= 1'b1;
            wa_o_r      <= pend_wa_r;
            we_o_r      <= pend_we_r;
            wn_r        <= mul_res_s;
            state_r     <= IDLE;
          end else begin
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end
`else
  assign in_ready = !rst;
  // flush wins over a simultaneous accept
  assign accept_s = in_valid && in_ready && !flush;

  // Output registers for single-cycle ops
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      wa_o_r      <= 5'd0;
      we_o_r      <= 1'b0;
      wn_r        <= {XLEN{1'b0}};
    end else if (flush) begin
      out_valid_r <= 1'b0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      wa_o_r      <= wa;
      we_o_r      <= we && supported_s;
      wn_r        <= alu_res_s;
    end else begin
      out_valid_r <= 1'b0;
    end
  end
`endif

  assign out_valid = out_valid_r;
  assign wa_o      = wa_o_r;
  assign we_o      = we_o_r;
  assign wn        = wn_r;

endmodule

// File: tb/tb_ex_alu.sv
// tb_ex_alu: self-checking bench for ex_alu (XLEN = 32). A behavioural model
// tracks the expected outputs every cycle; directed tests add literal checks.
// Build with EX_MUL_EN defined to exercise the multiplier.
module tb_ex_alu;

  localparam int XLEN = 32;
  localparam logic [6:0] T_OP  = 7'b0110011;
  localparam logic [6:0] T_IMM = 7'b0010011;
  localparam logic [6:0] T_LUI = 7'b0110111;
  localparam logic [6:0] T_AUI = 7'b0010111;
`ifdef EX_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [6:0]  t = 7'd0;
  logic [2:0]  st = 3'd0;
  logic        sst = 1'b0;
  logic        m = 1'b0;
  logic [31:0] n1 = 32'd0;
  logic [31:0] n2 = 32'd0;
  logic [4:0]  wa = 5'd0;
  logic        we = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [4:0]  wa_o;
  logic        we_o;
  logic [31:0] wn;

  ex_alu #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .t(t), .st(st), .sst(sst), .m(m), .n1(n1), .n2(n2), .wa(wa), .we(we),
    .out_valid(out_valid), .wa_o(wa_o), .we_o(we_o), .wn(wn)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  // Reference semantics of one op. is_mul: op occupies the multiplier.
  // ok: op is supported (we_o follows we). r: result value.
  function automatic void ref_exec(input logic [6:0] op, input logic [2:0] f3, input logic s7,
                                   input logic mm, input logic [31:0] a, input logic [31:0] b,
                                   output logic is_mul, output logic ok, output logic [31:0] r);
    logic [4:0]  sh;
    logic [63:0] pa, pb, p;
    logic [31:0] ones;
    sh = b[4:0];
    ones = 32'hFFFF_FFFF;
    is_mul = 1'b0;
    ok = 1'b1;
    r = 32'd0;
    if (op == T_LUI) r = b;
    else if (op == T_AUI) r = a + b;
    else if ((op == T_OP && !mm) || op == T_IMM) begin
      case (f3)
        3'd0: r = (op == T_OP && s7) ? a - b : a + b;
        3'd1: r = a << sh;
        3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        3'd3: r = (a < b) ? 32'd1 : 32'd0;
        3'd4: r = a ^ b;
        3'd5: r = (a >> sh) | ((s7 && a[31]) ? ~(ones >> sh) : 32'd0);
        3'd6: r = a | b;
        default: r = a & b;
      endcase
    end else if (op == T_OP && mm && MUL_EN && !f3[2]) begin
      is_mul = 1'b1;
      pa = (f3 == 3'd1 || f3 == 3'd2) ? {{32{a[31]}}, a} : {32'd0, a};
      pb = (f3 == 3'd1) ? {{32{b[31]}}, b} : {32'd0, b};
      p = pa * pb;
      r = (f3 == 3'd0) ? p[31:0] : p[63:32];
    end else begin
      ok = 1'b0;
    end
  endfunction

  // Model state
  bit          m_init = 1'b0;
  int          m_busy = 0;
  bit          e_valid = 1'b0;
  bit          e_zero = 1'b0;
  logic [4:0]  e_wa, p_wa;
  logic        e_we, p_we;
  logic [31:0] e_wn, p_wn;
  logic        r_mul, r_ok;
  logic [31:0] r_val;

  logic [31:0] log_wn[$];
  int          log_cyc[$];

  // Model update on each rising edge using the inputs as the DUT saw them
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_init = 1'b1; m_busy = 0; e_valid = 1'b0; e_zero = 1'b1;
    end else begin
      e_zero = 1'b0;
      if (flush) begin
        m_busy = 0; e_valid = 1'b0;
      end else if (m_busy > 0) begin
        m_busy--;
        e_valid = (m_busy == 0);
        if (m_busy == 0) begin
          e_wa = p_wa; e_we = p_we; e_wn = p_wn;
        end
      end else if (in_valid) begin
        ref_exec(t, st, sst, m, n1, n2, r_mul, r_ok, r_val);
        if (r_mul) begin
          m_busy = XLEN; p_wa = wa; p_we = we; p_wn = r_val; e_valid = 1'b0;
        end else begin
          e_valid = 1'b1; e_wa = wa; e_we = we && r_ok; e_wn = r_val;
        end
      end else begin
        e_valid = 1'b0;
      end
    end
  end

  // Compare DUT against the model away from the active edge
  always @(negedge clk) begin
    if (m_init) begin
      check1("in_ready", in_ready, !rst && (m_busy == 0));
      check1("out_valid", out_valid, e_valid);
      if (e_zero) begin
        check32("rst_wa_o", {27'd0, wa_o}, 32'd0);
        check1("rst_we_o", we_o, 1'b0);
        check32("rst_wn", wn, 32'd0);
      end else if (e_valid) begin
        check32("wa_o", {27'd0, wa_o}, {27'd0, e_wa});
        check1("we_o", we_o, e_we);
        check32("wn", wn, e_wn);
      end
      if (out_valid) begin
        log_wn.push_back(wn);
        log_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic s7, input logic mm,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] d, input logic w);
    in_valid = 1'b1; t = op; st = f3; sst = s7; m = mm; n1 = a; n2 = b; wa = d; we = w;
    tick();
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: pick = 32'h0000_0000;
      1: pick = 32'h8000_0000;
      2: pick = 32'hFFFF_FFFF;
      3: pick = 32'h7FFF_FFFF;
      4: pick = 32'h0000_0001;
      default: pick = $urandom;
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lows;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // ORI
    drive(T_IMM, 3'b110, 1'b0, 1'b0, 32'h0000_00F0, 32'h0000_000F, 5'd3, 1'b1);
    @(negedge clk);
    check1("ori_valid", out_valid, 1'b1);
    check32("ori_wn", wn, 32'h0000_00FF);
    tick();

    // Back-to-back SUB, SRA, SLTU
    log_wn.delete(); log_cyc.delete();
    drive(T_OP, 3'b000, 1'b1, 1'b0, 32'd5, 32'd7, 5'd1, 1'b1);
    drive(T_OP, 3'b101, 1'b1, 1'b0, 32'h8000_0000, 32'd4, 5'd2, 1'b1);
    drive(T_OP, 3'b011, 1'b0, 1'b0, 32'd1, 32'hFFFF_FFFF, 5'd4, 1'b1);
    repeat (3) tick();
    check32("b2b_count", log_wn.size(), 32'd3);
    if (log_wn.size() == 3) begin
      check32("b2b_sub", log_wn[0], 32'hFFFF_FFFE);
      check32("b2b_sra", log_wn[1], 32'hF800_0000);
      check32("b2b_sltu", log_wn[2], 32'h0000_0001);
      check32("b2b_consec", log_cyc[2] - log_cyc[0], 32'd2);
    end

    // Unsupported opcode and LUI
    drive(7'b0000011, 3'b010, 1'b0, 1'b0, 32'h1111_1111, 32'h2222_2222, 5'd5, 1'b1);
    @(negedge clk);
    check1("unsup_valid", out_valid, 1'b1);
    check1("unsup_we", we_o, 1'b0);
    check32("unsup_wn", wn, 32'd0);
    tick();
    drive(T_LUI, 3'b000, 1'b0, 1'b0, 32'h0, 32'h1234_5000, 5'd6, 1'b1);
    @(negedge clk);
    check32("lui_wn", wn, 32'h1234_5000);
    tick();

    // flush beats a simultaneous accept
    in_valid = 1'b1; t = T_OP; st = 3'b000; sst = 1'b0; m = 1'b0; n1 = 32'd1; n2 = 32'd2; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check1("flush_accept", out_valid, 1'b0);
    tick();

`ifndef EX_MUL_EN
    // M-extension op without the multiplier completes as unsupported
    drive(T_OP, 3'b000, 1'b0, 1'b1, 32'd3, 32'd4, 5'd7, 1'b1);
    @(negedge clk);
    check1("nomul_valid", out_valid, 1'b1);
    check1("nomul_we", we_o, 1'b0);
    check32("nomul_wn", wn, 32'd0);
    tick();
`else
    // MULH with an ADD held during the stall
    log_wn.delete(); log_cyc.delete();
    drive(T_OP, 3'b001, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0002, 5'd9, 1'b1);
    in_valid = 1'b1; t = T_OP; st = 3'b000; sst = 1'b0; m = 1'b0; n1 = 32'd10; n2 = 32'd20; wa = 5'd10;
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) break;
      lows++;
    end
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    check32("mul_stall_len", lows, 32'd32);
    check32("mul_count", log_wn.size(), 32'd2);
    if (log_wn.size() == 2) begin
      check32("mulh_wn", log_wn[0], 32'hFFFF_FFFF);
      check32("held_add_wn", log_wn[1], 32'd30);
      check32("held_add_next", log_cyc[1] - log_cyc[0], 32'd1);
    end

    // MULHU and MUL corner cases
    log_wn.delete(); log_cyc.delete();
    drive(T_OP, 3'b011, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 1'b1);
    repeat (34) tick();
    drive(T_OP, 3'b000, 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 5'd12, 1'b1);
    repeat (34) tick();
    check32("mul2_count", log_wn.size(), 32'd2);
    if (log_wn.size() == 2) begin
      check32("mulhu_wn", log_wn[0], 32'hFFFF_FFFE);
      check32("mul_minneg_wn", log_wn[1], 32'h0000_0000);
    end

    // flush at cycle 10 of a multiply
    log_wn.delete(); log_cyc.delete();
    drive(T_OP, 3'b000, 1'b0, 1'b1, 32'd3, 32'd5, 5'd13, 1'b1);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    check1("flush_mul_ready", in_ready, 1'b1);
    check1("flush_mul_valid", out_valid, 1'b0);
    repeat (40) tick();
    check32("flush_mul_noresult", log_wn.size(), 32'd0);

    // rst at cycle 10 of a multiply
    drive(T_OP, 3'b000, 1'b0, 1'b1, 32'd3, 32'd5, 5'd14, 1'b1);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check1("rst_mul_ready", in_ready, 1'b1);
    check1("rst_mul_valid", out_valid, 1'b0);
    check32("rst_mul_wn", wn, 32'd0);
    repeat (40) tick();
    check32("rst_mul_noresult", log_wn.size(), 32'd0);
`endif

    // Randomised traffic checked by the model
    for (int i = 0; i < 600; i++) begin
      in_valid = ($urandom_range(0, 99) < 70);
      case ($urandom_range(0, 5))
        0: t = T_OP;
        1: t = T_IMM;
        2: t = T_OP;
        3: t = T_LUI;
        4: t = T_AUI;
        default: t = 7'($urandom);
      endcase
      st = 3'($urandom);
      sst = 1'($urandom);
      m = ($urandom_range(0, 9) == 0);
      n1 = pick();
      n2 = pick();
      wa = 5'($urandom);
      we = 1'($urandom);
      flush = ($urandom_range(0, 49) == 0);
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; rst = 1'b0;
    repeat (40) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_alu.md
# ex_alu

Registered RV32I execute stage, parametrised in data width, sitting between decode and memory-access in the core pipeline. Computes every OP/OP-IMM ALU function plus LUI/AUIPC in one cycle. Optionally computes the M-extension multiplies with an iterative shift-add unit that stalls decode through a valid/ready handshake. Supports a pipeline flush.

## Interface
- XLEN, 32, datapath width; shift amount is n2[$clog2(XLEN)-1:0]

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  synchronous squash of the current op and any in-flight multiply
- in_valid  in  1  decode presents an op this cycle
- in_ready  out  1  stage accepts an op this cycle; an op is accepted on an edge where in_valid && in_ready
- t  in  7  opcode
- st  in  3  funct3
- sst  in  1  funct7[5]: SUB/SRA select
- m  in  1  funct7 == 7'b0000001 (M-extension)
- n1  in  XLEN  operand 1: rs1, or PC for AUIPC
- n2  in  XLEN  operand 2: rs2 or immediate; U-imm already shifted for LUI/AUIPC
- wa  in  5  destination register
- we  in  1  write-enable from decode
- out_valid  out  1  wa_o/we_o/wn are a new result; one-cycle pulse per op
- wa_o  out  5  registered destination
- we_o  out  1  registered write-enable
- wn  out  XLEN  registered result

## Operation
- OP-IMM 0010011 / OP 0110011 with m=0, by st:
  - 000: ADD, or SUB when t=OP && sst.
  - 001: SLL.
  - 010: SLT (signed).
  - 011: SLTU.
  - 100: XOR.
  - 101: SRL, or SRA when sst.
  - 110: OR.
  - 111: AND.
- SLT/SLTU: wn = {XLEN-1 zeros, flag}. Add/sub wrap modulo 2^XLEN.
- LUI 0110111: wn = n2. AUIPC 0010111: wn = n1 + n2.
- Any other opcode, or OP with m=1 when the multiplier is not compiled in:
  - wn = 0, we_o = 0, wa_o = wa.
  - Still a single-cycle op with out_valid = 1.
- State machine:
  - IDLE: in_ready = 1. Single-cycle ops stay in IDLE. An accepted OP with m=1 and st[2]=0 captures operands, wa and we, then moves to MUL.
  - MUL: in_ready = 0, in_valid ignored. ex_mul iterates once per cycle for XLEN cycles, then writes the result and returns to IDLE.
- MUL: low XLEN bits of the product. MULH: high bits, signed × signed. MULHSU: high bits, signed × unsigned. MULHU: high bits, unsigned × unsigned.
- Signed operands are converted to magnitudes, an unsigned 2·XLEN product is formed, and it is negated if the signs differ. Most-negative × most-negative is exact.
- M-extension st[2]=1 (DIV/REM) is handled as unsupported.
- flush:
  - Next cycle: out_valid = 0, state IDLE.
  - An op presented in the same cycle is not accepted.
  - Other outputs are not guaranteed.
- rst: state IDLE, out_valid = 0, wa_o = 0, we_o = 0, wn = 0, in_ready = 0 while rst is high. A multiply in flight is aborted and produces no result.

## Timing
- Single-cycle op accepted at edge E: result and out_valid = 1 in the cycle after E. Back-to-back accepts give out_valid on consecutive cycles.
- Multiply accepted at edge E:
  - in_ready = 0 from after E until after edge E+XLEN.
  - Result and out_valid = 1 in the cycle after E+XLEN. in_ready = 1 in that same cycle.
  - Latency is XLEN cycles.
- out_valid drops after one cycle unless a new result is written on that edge. Downstream always accepts.
- flush beats a simultaneous accept. rst beats flush.

## Configuration
- EX_MUL_EN defined: ex_mul is instantiated and the MUL state exists.
- EX_MUL_EN undefined: no multiplier logic and in_ready is tied to !rst. m=1 ops complete in one cycle as unsupported (wn = 0, we_o = 0).

## Structure
- Package ex_pkg holds:
  - opcode constants OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC;
  - funct3 constants;
  - the state enum {IDLE, MUL}.
- Sub-module ex_mul:
  - Iterative shift-add multiplier with ports start, a, b, a_signed, b_signed, hi_sel, done, result.
  - Owns the iteration counter and the sign fix-up.
  - ex_alu owns the handshake and the output registers.

## Test plan
- Reset, then ORI n1=0x0000_00F0 n2=0x0000_000F → wn=0x0000_00FF, out_valid one cycle after accept. All outputs are 0 during rst.
- Back-to-back: SUB 5−7, SRA 0x8000_0000>>4, SLTU 1<0xFFFF_FFFF:
  - wn = 0xFFFF_FFFE, 0xF800_0000, 0x0000_0001 on three consecutive cycles.
- Unsupported opcode 0000011 with we=1 → wn=0, we_o=0, out_valid=1. Also LUI n2=0x1234_5000 → wn=0x1234_5000.
- EX_MUL_EN, MULH 0xFFFF_FFFF×0x0000_0002 → wn=0xFFFF_FFFF.
  - in_ready is low exactly 32 cycles.
  - An in_valid ADD held during the stall is accepted the cycle in_ready returns.
- EX_MUL_EN, MULHU 0xFFFF_FFFF×0xFFFF_FFFF → 0xFFFF_FFFE. MUL 0x8000_0000×0x8000_0000 → 0x0000_0000.
- flush at cycle 10 of a MUL → no out_valid, in_ready=1 next cycle. Repeat with rst instead of flush → same result, and outputs read 0.
